// File: rtl/rs_pkg.sv
// Shared widths and payload layout for the reservation-station slice.
package rs_pkg;

    localparam int unsigned RS_ROB_W     = 4;
    localparam int unsigned RS_DATA_W    = 32;
    localparam int unsigned RS_PAYLOAD_W = 80;

    // The payload travels through the station unmodified. This layout is what the
    // decoder packs and the ALU unpacks. Only opcode[6:2] is carried because the
    // two low opcode bits are always 2'b11 for 32-bit instructions.
    localparam int unsigned PAY_PC_LSB     = 0;
    localparam int unsigned PAY_PC_W       = 32;
    localparam int unsigned PAY_IMM_LSB    = 32;
    localparam int unsigned PAY_IMM_W      = 32;
    localparam int unsigned PAY_FUNCT7_LSB = 64;
    localparam int unsigned PAY_FUNCT7_W   = 7;
    localparam int unsigned PAY_FUNCT3_LSB = 71;
    localparam int unsigned PAY_FUNCT3_W   = 3;
    localparam int unsigned PAY_OPCODE_LSB = 74;
    localparam int unsigned PAY_OPCODE_W   = 5;

    typedef struct packed {
        logic                    rsvd;
        logic [PAY_OPCODE_W-1:0] opcode;
        logic [PAY_FUNCT3_W-1:0] funct3;
        logic [PAY_FUNCT7_W-1:0] funct7;
        logic [PAY_IMM_W-1:0]    imm;
        logic [PAY_PC_W-1:0]     pc;
    } rs_payload_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready entry that has no older ready entry.
module rs_age_select #(
    parameter int unsigned DEPTH = 16
) (
    input  logic [DEPTH-1:0]            i_ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] i_older,
    output logic [DEPTH-1:0]            o_grant,
    output logic                        o_valid
);

    // Row i of the matrix lists the entries older than i. Masked by ready, an empty row wins.
    always_comb begin
        o_grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_grant[i] = i_ready[i] && ((i_older[i] & i_ready) == '0);
        end
    end

    assign o_valid = |i_ready;

endmodule

// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station: CDB operand capture, oldest-ready dispatch.
module rs_age_ordered
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned ROB_W     = RS_ROB_W,
    parameter int unsigned DATA_W    = RS_DATA_W,
    parameter int unsigned PAYLOAD_W = RS_PAYLOAD_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rollback,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [ROB_W-1:0]            issue_rob_pos,
    input  logic                        issue_q1_busy,
    input  logic [ROB_W-1:0]            issue_q1_tag,
    input  logic [DATA_W-1:0]           issue_v1,
    input  logic                        issue_q2_busy,
    input  logic [ROB_W-1:0]            issue_q2_tag,
    input  logic [DATA_W-1:0]           issue_v2,
    input  logic [PAYLOAD_W-1:0]        issue_payload,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_val,
    output logic                        disp_valid,
    input  logic                        disp_ready,
    output logic [DATA_W-1:0]           disp_v1,
    output logic [DATA_W-1:0]           disp_v2,
    output logic [PAYLOAD_W-1:0]        disp_payload,
    output logic [ROB_W-1:0]            disp_rob_pos,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]            r_busy;
    logic [DEPTH-1:0]            r_q1_busy;
    logic [DEPTH-1:0]            r_q2_busy;
    logic [ROB_W-1:0]            r_q1_tag  [DEPTH];
    logic [ROB_W-1:0]            r_q2_tag  [DEPTH];
    logic [DATA_W-1:0]           r_v1      [DEPTH];
    logic [DATA_W-1:0]           r_v2      [DEPTH];
    logic [PAYLOAD_W-1:0]        r_payload [DEPTH];
    logic [ROB_W-1:0]            r_rob_pos [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] r_older;
    logic [CNT_W-1:0]            r_count;

    logic [DEPTH-1:0]            w_ready;
    logic [DEPTH-1:0]            w_grant;
    logic                        w_any_ready;
    logic                        w_issue_fire;
    logic                        w_disp_fire;
    logic [IDX_W-1:0]            w_free_idx;
    logic [DEPTH-1:0]            w_disp_mask;
    logic [DATA_W:0]             w_q1_wake [DEPTH];
    logic [DATA_W:0]             w_q2_wake [DEPTH];
    logic [DATA_W:0]             w_iss_q1_wake;
    logic [DATA_W:0]             w_iss_q2_wake;

    // Returns {hit, value} for a tag against all valid CDB ports; the lowest port wins.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (cdb_valid[p] && (cdb_tag[p*ROB_W +: ROB_W] == tag)) begin
                res = {1'b1, cdb_val[p*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    assign issue_ready  = (r_count != CNT_W'(DEPTH));
    assign count        = r_count;
    assign w_ready      = r_busy & ~r_q1_busy & ~r_q2_busy;
    assign disp_valid   = w_any_ready;
    assign w_issue_fire = issue_valid && issue_ready;
    assign w_disp_fire  = w_any_ready && disp_ready;
    assign w_disp_mask  = w_grant & {DEPTH{w_disp_fire}};

    rs_age_select #(
        .DEPTH(DEPTH)
    ) u_age_select (
        .i_ready (w_ready),
        .i_older (r_older),
        .o_grant (w_grant),
        .o_valid (w_any_ready)
    );

    // Lowest-index free slot; only meaningful while the station is not full.
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // CDB matches for every stored operand and for the operands being issued.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_q1_wake[i] = cdb_lookup(r_q1_tag[i]);
            w_q2_wake[i] = cdb_lookup(r_q2_tag[i]);
        end
        w_iss_q1_wake = cdb_lookup(issue_q1_tag);
        w_iss_q2_wake = cdb_lookup(issue_q2_tag);
    end

    // Dispatch mux driven by the one-hot grant.
    always_comb begin
        disp_v1      = '0;
        disp_v2      = '0;
        disp_payload = '0;
        disp_rob_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                disp_v1      = r_v1[i];
                disp_v2      = r_v2[i];
                disp_payload = r_payload[i];
                disp_rob_pos = r_rob_pos[i];
            end
        end
    end

    // Entry state: wakeup, dispatch release, issue allocation and age bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            r_busy  <= '0;
            r_older <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy[i] && r_q1_busy[i] && w_q1_wake[i][DATA_W]) begin
                    r_q1_busy[i] <= 1'b0;
                    r_v1[i]      <= w_q1_wake[i][DATA_W-1:0];
                end
                if (r_busy[i] && r_q2_busy[i] && w_q2_wake[i][DATA_W]) begin
                    r_q2_busy[i] <= 1'b0;
                    r_v2[i]      <= w_q2_wake[i][DATA_W-1:0];
                end
                if (w_disp_mask[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
            if (w_issue_fire) begin
                // The new entry is younger than everything that stays; nothing is older than it in other rows.
                for (int i = 0; i < DEPTH; i++) begin
                    r_older[i][w_free_idx] <= 1'b0;
                end
                r_older[w_free_idx]   <= r_busy & ~w_disp_mask;
                r_busy[w_free_idx]    <= 1'b1;
                r_rob_pos[w_free_idx] <= issue_rob_pos;
                r_payload[w_free_idx] <= issue_payload;
                r_q1_tag[w_free_idx]  <= issue_q1_tag;
                r_q2_tag[w_free_idx]  <= issue_q2_tag;
                r_q1_busy[w_free_idx] <= issue_q1_busy && !w_iss_q1_wake[DATA_W];
                r_q2_busy[w_free_idx] <= issue_q2_busy && !w_iss_q2_wake[DATA_W];
                r_v1[w_free_idx]      <= (issue_q1_busy && w_iss_q1_wake[DATA_W])
                                         ? w_iss_q1_wake[DATA_W-1:0] : issue_v1;
                r_v2[w_free_idx]      <= (issue_q2_busy && w_iss_q2_wake[DATA_W])
                                         ? w_iss_q2_wake[DATA_W-1:0] : issue_v2;
            end
            r_count <= r_count + CNT_W'(w_issue_fire) - CNT_W'(w_disp_fire);
        end
    end

endmodule

// File: tb/tb_rs_age_ordered.sv
// Scoreboard bench for rs_age_ordered against an age-ordered queue model.
module tb_rs_age_ordered;

    localparam int DEPTH     = 16;
    localparam int NUM_CDB   = 2;
    localparam int ROB_W     = 4;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 80;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      rollback;
    logic                      issue_valid;
    logic                      issue_ready;
    logic [ROB_W-1:0]          issue_rob_pos;
    logic                      issue_q1_busy;
    logic [ROB_W-1:0]          issue_q1_tag;
    logic [DATA_W-1:0]         issue_v1;
    logic                      issue_q2_busy;
    logic [ROB_W-1:0]          issue_q2_tag;
    logic [DATA_W-1:0]         issue_v2;
    logic [PAYLOAD_W-1:0]      issue_payload;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*ROB_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_val;
    logic                      disp_valid;
    logic                      disp_ready;
    logic [DATA_W-1:0]         disp_v1;
    logic [DATA_W-1:0]         disp_v2;
    logic [PAYLOAD_W-1:0]      disp_payload;
    logic [ROB_W-1:0]          disp_rob_pos;
    logic [$clog2(DEPTH):0]    count;

    always #5 clk = ~clk;

    rs_age_ordered #(
        .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk), .rst(rst), .rollback(rollback),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rob_pos(issue_rob_pos),
        .issue_q1_busy(issue_q1_busy), .issue_q1_tag(issue_q1_tag), .issue_v1(issue_v1),
        .issue_q2_busy(issue_q2_busy), .issue_q2_tag(issue_q2_tag), .issue_v2(issue_v2),
        .issue_payload(issue_payload),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_payload(disp_payload),
        .disp_rob_pos(disp_rob_pos), .count(count)
    );

    // Model entry; the queue position is its age (front = oldest).
    typedef struct {
        logic [ROB_W-1:0]     rob;
        logic                 q1b;
        logic [ROB_W-1:0]     q1t;
        logic [DATA_W-1:0]    v1;
        logic                 q2b;
        logic [ROB_W-1:0]     q2t;
        logic [DATA_W-1:0]    v2;
        logic [PAYLOAD_W-1:0] pay;
    } ent_t;

    typedef struct packed {
        logic [ROB_W-1:0]     rob;
        logic [DATA_W-1:0]    v1;
        logic [DATA_W-1:0]    v2;
        logic [PAYLOAD_W-1:0] pay;
    } disp_t;

    ent_t  mq[$];
    disp_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    checks_on = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // First valid CDB port (in port order) broadcasting the tag.
    function automatic void lookup(input logic [ROB_W-1:0] tag, output bit hit, output logic [DATA_W-1:0] val);
        hit = 1'b0;
        val = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (!hit && cdb_valid[p] && cdb_tag[p*ROB_W +: ROB_W] == tag) begin
                hit = 1'b1;
                val = cdb_val[p*DATA_W +: DATA_W];
            end
        end
    endfunction

    function automatic logic [PAYLOAD_W-1:0] rpay();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[PAYLOAD_W-1:0];
    endfunction

    // Compare visible state with the model, then advance the model across the coming edge.
    task automatic model_step();
        int   sel;
        bit   hit;
        logic [DATA_W-1:0] v;
        ent_t n;
        disp_t d;
        sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].q1b && !mq[i].q2b) begin
                sel = i;
                break;
            end
        end
        if (checks_on) begin
            check("issue_ready", 32'(issue_ready), 32'(mq.size() != DEPTH));
            check("count", 32'(count), 32'(mq.size()));
            check("disp_valid", 32'(disp_valid), 32'(sel >= 0));
        end
        if (rst || rollback) begin
            mq.delete();
            checks_on = 1'b1;
            return;
        end
        if (sel >= 0 && disp_ready) begin
            d.rob = mq[sel].rob; d.v1 = mq[sel].v1; d.v2 = mq[sel].v2; d.pay = mq[sel].pay;
            exp_q.push_back(d);
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].q1b) begin
                lookup(mq[i].q1t, hit, v);
                if (hit) begin mq[i].q1b = 1'b0; mq[i].v1 = v; end
            end
            if (mq[i].q2b) begin
                lookup(mq[i].q2t, hit, v);
                if (hit) begin mq[i].q2b = 1'b0; mq[i].v2 = v; end
            end
        end
        if (issue_valid && mq.size() < DEPTH) begin
            n.rob = issue_rob_pos; n.pay = issue_payload;
            n.q1t = issue_q1_tag;  n.q1b = issue_q1_busy; n.v1 = issue_v1;
            n.q2t = issue_q2_tag;  n.q2b = issue_q2_busy; n.v2 = issue_v2;
            if (n.q1b) begin lookup(n.q1t, hit, v); if (hit) begin n.q1b = 1'b0; n.v1 = v; end end
            if (n.q2b) begin lookup(n.q2t, hit, v); if (hit) begin n.q2b = 1'b0; n.v2 = v; end end
            if (sel >= 0 && disp_ready) mq.delete(sel);
            mq.push_back(n);
        end else if (sel >= 0 && disp_ready) begin
            mq.delete(sel);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rollback = 1'b0; issue_valid = 1'b0; disp_ready = 1'b0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    task automatic set_issue(input logic [ROB_W-1:0] rob, input logic q1b, input logic [ROB_W-1:0] q1t,
                             input logic q2b, input logic [ROB_W-1:0] q2t);
        issue_valid = 1'b1; issue_rob_pos = rob; issue_payload = rpay();
        issue_q1_busy = q1b; issue_q1_tag = q1t; issue_v1 = $urandom();
        issue_q2_busy = q2b; issue_q2_tag = q2t; issue_v2 = $urandom();
    endtask

    task automatic fill_ready(input int n);
        for (int r = 0; r < n; r++) begin
            set_issue(ROB_W'(r), 1'b0, '0, 1'b0, '0);
            cycle();
        end
        issue_valid = 1'b0;
    endtask

    // Dispatch monitor: every accepted dispatch must match the next model prediction.
    initial begin
        disp_t a, e;
        forever begin
            @(negedge clk);
            #2;
            if (checks_on && !rst && !rollback && disp_valid === 1'b1 && disp_ready === 1'b1) begin
                a.rob = disp_rob_pos; a.v1 = disp_v1; a.v2 = disp_v2; a.pay = disp_payload;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dispatch: got rob %0h, expected no dispatch (t=%0t)", a.rob, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL dispatch: got rob %0h v1 %0h v2 %0h pay %0h, expected rob %0h v1 %0h v2 %0h pay %0h",
                                 a.rob, a.v1, a.v2, a.pay, e.rob, e.v1, e.v2, e.pay);
                    end
                end
            end
        end
    end

    initial begin
        idle();
        issue_rob_pos = '0; issue_payload = '0; issue_q1_busy = 1'b0; issue_q1_tag = '0;
        issue_v1 = '0; issue_q2_busy = 1'b0; issue_q2_tag = '0; issue_v2 = '0;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // Fill, attempt overflow, then drain in issue order.
        fill_ready(DEPTH);
        set_issue(4'hF, 1'b0, '0, 1'b0, '0);
        cycle();
        issue_valid = 1'b0; disp_ready = 1'b1;
        repeat (DEPTH + 1) cycle();
        idle();

        // Younger ready entry overtakes an older waiting one; wakeup on port 1.
        set_issue(4'd1, 1'b1, 4'd5, 1'b0, '0); cycle();
        set_issue(4'd2, 1'b0, '0, 1'b0, '0);   cycle();
        issue_valid = 1'b0; disp_ready = 1'b1;
        cdb_valid = 2'b10; cdb_tag = {4'd5, 4'd0}; cdb_val = {32'hDEAD, 32'h0};
        cycle();
        cdb_valid = '0;
        repeat (2) cycle();
        idle();

        // Broadcast in the issue cycle is captured.
        set_issue(4'd3, 1'b0, '0, 1'b1, 4'd3);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_val = {32'h0, 32'h1234};
        cycle();
        idle(); disp_ready = 1'b1;
        repeat (2) cycle();
        idle();

        // Two ports on the same tag: port 0 wins.
        set_issue(4'd4, 1'b1, 4'd7, 1'b0, '0); cycle();
        issue_valid = 1'b0;
        cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd7}; cdb_val = {32'h2, 32'h1};
        cycle();
        idle(); disp_ready = 1'b1;
        repeat (2) cycle();
        idle();

        // Rollback and reset override issue and dispatch.
        fill_ready(9);
        set_issue(4'd9, 1'b0, '0, 1'b0, '0); disp_ready = 1'b1; rollback = 1'b1;
        cycle();
        idle(); cycle();
        fill_ready(5);
        set_issue(4'd5, 1'b0, '0, 1'b0, '0); disp_ready = 1'b1; rst = 1'b1;
        cycle();
        idle(); cycle();

        // Full station: simultaneous issue and dispatch does not issue; next cycle it does.
        fill_ready(DEPTH);
        set_issue(4'hA, 1'b0, '0, 1'b0, '0); disp_ready = 1'b1;
        cycle();
        set_issue(4'hB, 1'b0, '0, 1'b0, '0); disp_ready = 1'b0;
        cycle();
        idle(); disp_ready = 1'b1;
        repeat (DEPTH + 1) cycle();
        idle();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(399) == 0);
            rollback    = ($urandom_range(79) == 0);
            disp_ready  = ($urandom_range(2) != 0);
            issue_valid = ($urandom_range(1) == 0);
            issue_rob_pos = 4'($urandom_range(15));
            issue_payload = rpay();
            issue_q1_busy = ($urandom_range(1) == 0); issue_q1_tag = 4'($urandom_range(15)); issue_v1 = $urandom();
            issue_q2_busy = ($urandom_range(2) == 0); issue_q2_tag = 4'($urandom_range(15)); issue_v2 = $urandom();
            for (int p = 0; p < NUM_CDB; p++) begin
                cdb_valid[p] = ($urandom_range(4) < 2);
                cdb_tag[p*ROB_W +: ROB_W]   = 4'($urandom_range(15));
                cdb_val[p*DATA_W +: DATA_W] = $urandom();
            end
            cycle();
        end

        // Drain: broadcast every tag so all waiting entries can leave.
        idle(); disp_ready = 1'b1;
        for (int t = 0; t < 16; t += 2) begin
            cdb_valid = 2'b11; cdb_tag = {4'(t + 1), 4'(t)}; cdb_val = {$urandom(), $urandom()};
            cycle();
        end
        cdb_valid = '0;
        repeat (DEPTH + 2) cycle();
        @(negedge clk);
        #3;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("final_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
